// File: rtl/tone_player.sv
// tone_player: plays the C4..C5 scale as a square wave on one pin.
// Tempo comes from a divided clock that is sampled as an asynchronous level
// and edge-detected; every register here is clocked by clk_in alone.
module tone_player #(
  parameter int CLK_HZ     = 50000000,
  parameter int NOTE_TICKS = 4,
  parameter int GAP_TICKS  = 1
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_clk,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic       audio_out,
  output logic       busy,
  output logic [2:0] note_idx,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Scale frequencies in Hz, indexed by note_idx.
  localparam int FREQ [8] = '{262, 294, 330, 349, 392, 440, 494, 523};

  // Terminal tick counts; a zero gap never reaches the GAP state, so its
  // terminal value only has to be a legal constant.
  localparam logic [15:0] NOTE_LAST = 16'((NOTE_TICKS > 1) ? NOTE_TICKS - 1 : 0);
  localparam logic [15:0] GAP_LAST  = 16'((GAP_TICKS  > 1) ? GAP_TICKS  - 1 : 0);

  // Terminal half-period count per note (half period minus one).
  logic [31:0] w_hp_last [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_half_period
    localparam int HP_RAW = CLK_HZ / (2 * FREQ[gi]);
    // Clamp to one cycle so a tiny CLK_HZ still yields a valid toggle rate.
    localparam int HP     = (HP_RAW < 1) ? 1 : HP_RAW;
    assign w_hp_last[gi] = 32'(HP - 1);
  end

  // Registered state
  state_t      r_state;
  logic [2:0]  r_note;
  logic [31:0] r_half_cnt;
  logic [15:0] r_tick_cnt;
  logic        r_tone;
  logic        r_s1;
  logic        r_s2;
  logic        r_s3;
  logic        r_audio;
  logic        r_busy;
  logic        r_done;

  // Next-state values
  state_t      w_state_next;
  logic [2:0]  w_note_next;
  logic [31:0] w_half_next;
  logic [15:0] w_tick_next;
  logic        w_tone_next;
  logic        w_done_next;
  logic        w_advance;
  logic        w_abort;
  logic        w_tick;
  logic [31:0] w_cur_last;

  assign w_tick     = r_s2 & ~r_s3;
  assign w_cur_last = w_hp_last[r_note];

  // Synchronise the divided clock and keep one extra stage for edge detect.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= tick_clk;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Next-state logic: transitions, tone generation and tick counting.
  always_comb begin
    w_state_next = r_state;
    w_note_next  = r_note;
    w_half_next  = r_half_cnt;
    w_tick_next  = r_tick_cnt;
    w_tone_next  = r_tone;
    w_done_next  = 1'b0;
    w_advance    = 1'b0;
    w_abort      = 1'b0;

    case (r_state)
      S_IDLE: begin
        // stop has priority over start while idle.
        if (start && !stop) begin
          w_state_next = S_PLAY;
          w_note_next  = 3'd0;
          w_half_next  = 32'd0;
          w_tick_next  = 16'd0;
          w_tone_next  = 1'b0;
        end
      end

      S_PLAY: begin
        if (stop) begin
          w_abort = 1'b1;
        end else begin
          if (r_half_cnt == w_cur_last) begin
            w_half_next = 32'd0;
            w_tone_next = ~r_tone;
          end else begin
            w_half_next = r_half_cnt + 32'd1;
          end

          if (w_tick) begin
            if (r_tick_cnt == NOTE_LAST) begin
              if (GAP_TICKS > 0) begin
                w_state_next = S_GAP;
                w_tick_next  = 16'd0;
                w_half_next  = 32'd0;
                w_tone_next  = 1'b0;
              end else begin
                w_advance = 1'b1;
              end
            end else begin
              w_tick_next = r_tick_cnt + 16'd1;
            end
          end
        end
      end

      S_GAP: begin
        if (stop) begin
          w_abort = 1'b1;
        end else if (w_tick) begin
          if (r_tick_cnt == GAP_LAST) begin
            w_advance = 1'b1;
          end else begin
            w_tick_next = r_tick_cnt + 16'd1;
          end
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_note_next  = 3'd0;
        w_half_next  = 32'd0;
        w_tick_next  = 16'd0;
        w_tone_next  = 1'b0;
      end
    endcase

    // Move to the next note, wrap when looping, or finish the sequence.
    // loop is only looked at here, on the note-7 decision.
    if (w_advance) begin
      w_half_next = 32'd0;
      w_tick_next = 16'd0;
      w_tone_next = 1'b0;
      if (r_note != 3'd7) begin
        w_state_next = S_PLAY;
        w_note_next  = r_note + 3'd1;
      end else if (loop) begin
        w_state_next = S_PLAY;
        w_note_next  = 3'd0;
      end else begin
        w_state_next = S_IDLE;
        w_note_next  = 3'd0;
        w_done_next  = 1'b1;
      end
    end

    // Abort returns to idle quietly, without a done pulse.
    if (w_abort) begin
      w_state_next = S_IDLE;
      w_note_next  = 3'd0;
      w_half_next  = 32'd0;
      w_tick_next  = 16'd0;
      w_tone_next  = 1'b0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_note     <= 3'd0;
      r_half_cnt <= 32'd0;
      r_tick_cnt <= 16'd0;
      r_tone     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_note     <= w_note_next;
      r_half_cnt <= w_half_next;
      r_tick_cnt <= w_tick_next;
      r_tone     <= w_tone_next;
    end
  end

  // Output registers, computed from next-state so they line up with state.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_audio <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_audio <= (w_state_next == S_PLAY) & w_tone_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= w_done_next;
    end
  end

  assign audio_out = r_audio;
  assign busy      = r_busy;
  assign note_idx  = r_note;
  assign done      = r_done;

endmodule

// File: tb/tb_tone_player.sv
// Directed bench for tone_player at CLK_HZ=5240, NOTE_TICKS=2 with a one-tick
// gap (dut) and without a gap (dut0). Tempo clock period is 400 clk cycles.
module tb_tone_player;

  logic       clk;
  logic       rst;
  logic       tick_clk;
  logic       start;
  logic       stop;
  logic       loop;
  logic       audio_out;
  logic       busy;
  logic [2:0] note_idx;
  logic       done;

  logic       start0;
  logic       audio_out0;
  logic       busy0;
  logic [2:0] note_idx0;
  logic       done0;

  int tests;
  int fails;
  int done_cnt;
  int done_base;

  tone_player #(.CLK_HZ(5240), .NOTE_TICKS(2), .GAP_TICKS(1)) dut (
    .clk_in(clk), .rst(rst), .tick_clk(tick_clk), .start(start), .stop(stop),
    .loop(loop), .audio_out(audio_out), .busy(busy), .note_idx(note_idx), .done(done)
  );

  tone_player #(.CLK_HZ(5240), .NOTE_TICKS(2), .GAP_TICKS(0)) dut0 (
    .clk_in(clk), .rst(rst), .tick_clk(tick_clk), .start(start0), .stop(1'b0),
    .loop(1'b0), .audio_out(audio_out0), .busy(busy0), .note_idx(note_idx0), .done(done0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tick_clk = 1'b0;
    forever #2000 tick_clk = ~tick_clk;
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_note(input string tag, input logic [2:0] idx, input int bound);
    int n = 0;
    while (note_idx !== idx && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(note_idx), 32'(idx));
  endtask

  // Wait for the next audio edge, then count cycles until the one after it.
  task automatic measure_half(input string tag, input int exp);
    logic prev;
    int n;
    prev = audio_out;
    n = 0;
    while (audio_out === prev && n < 50) begin
      @(negedge clk);
      n++;
    end
    prev = audio_out;
    n = 0;
    while (audio_out === prev && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n), 32'(exp));
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int n;
    tests = 0; fails = 0; done_cnt = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; start0 = 1'b0;
    cycles(3);
    check("rst_audio", 32'(audio_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_note", 32'(note_idx), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    cycles(2);

    // Start: busy right after the sampling edge, C4 half period 10.
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_audio", 32'(audio_out), 32'd0);
    check("start_note", 32'(note_idx), 32'd0);
    measure_half("c4_half", 10);
    wait_note("to_note1", 3'd1, 2000);
    // New note starts with tone low and first toggle a full half period later.
    n = 0;
    while (audio_out === 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("d4_first_toggle", 32'(n), 32'd8);
    measure_half("d4_half", 8);

    // Run to the end without looping.
    wait_note("to_note2", 3'd2, 2000);
    wait_note("to_note3", 3'd3, 2000);
    wait_note("to_note4", 3'd4, 2000);
    wait_note("to_note5", 3'd5, 2000);
    measure_half("a4_half", 5);
    wait_note("to_note6", 3'd6, 2000);
    wait_note("to_note7", 3'd7, 2000);
    check("no_early_done", 32'(done_cnt), 32'd0);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("end_busy", 32'(busy), 32'd0);
    check("end_done", 32'(done), 32'd1);
    check("end_note", 32'(note_idx), 32'd0);
    check("end_audio", 32'(audio_out), 32'd0);
    cycles(1);
    check("done_one_cycle", 32'(done), 32'd0);
    check("done_count", 32'(done_cnt), 32'd1);
    done_base = done_cnt;

    // Looping: three full wraps, never done, busy throughout.
    loop = 1'b1;
    pulse_start();
    for (int w = 0; w < 3; w++) begin
      wait_note($sformatf("loop%0d_n7", w), 3'd7, 12000);
      wait_note($sformatf("loop%0d_n0", w), 3'd0, 2000);
      check($sformatf("loop%0d_busy", w), 32'(busy), 32'd1);
    end
    check("loop_no_done", 32'(done_cnt), 32'(done_base));

    // Stop during note 3.
    loop = 1'b0;
    wait_note("stop_n3", 3'd3, 5000);
    cycles(17);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_audio", 32'(audio_out), 32'd0);
    check("stop_note", 32'(note_idx), 32'd0);
    cycles(3);
    check("stop_no_done", 32'(done_cnt), 32'(done_base));

    // start while busy is ignored.
    pulse_start();
    wait_note("busy_n2", 3'd2, 4000);
    cycles(5);
    pulse_start();
    cycles(2);
    check("restart_ignored", 32'(note_idx), 32'd2);
    check("restart_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    cycles(2);

    // start and stop together while idle: stay idle.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", 32'(busy), 32'd0);
    cycles(5);
    check("startstop_idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-playback.
    loop = 1'b1;
    pulse_start();
    wait_note("rst_mid_n1", 3'd1, 2000);
    cycles(4);
    stop = 1'($urandom_range(0, 1));
    #2 rst = 1'b1;
    #1;
    check("arst_audio", 32'(audio_out), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_note", 32'(note_idx), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    cycles(3);
    rst = 1'b0; stop = 1'b0; loop = 1'b0;
    cycles(50);
    check("arst_stay_idle", 32'(busy), 32'd0);

    // No-gap variant: next note begins on the ending tick.
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("gap0_busy", 32'(busy0), 32'd1);
    n = 0;
    while (note_idx0 !== 3'd1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("gap0_note1", 32'(note_idx0), 32'd1);
    check("gap0_busy_n1", 32'(busy0), 32'd1);
    n = 0;
    while (audio_out0 === 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("gap0_first_toggle", 32'(n), 32'd8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tone_player.md
# tone_player

Square-wave tone sequencer for the audio side of the VGA/audio test design. It sits directly downstream of the clock divider and uses the divider's slow output clock as a tempo reference. On each start request it plays a fixed 8-note scale (C4 to C5) on a single-bit audio pin, with an optional silent gap between notes and optional looping. All logic runs on the 50 MHz board clock. The divided clock is treated as an asynchronous level and is synchronised internally, never used as a clock.

## Interface
- CLK_HZ, 50000000: frequency of clk_in in Hz. Note half-periods are derived from it.
- NOTE_TICKS, 4: tempo ticks each note sounds (minimum 1).
- GAP_TICKS, 1: silent tempo ticks after each note (0 means no gap).
- clk_in  input  1  system clock. This is the only clock.
- rst  input  1  reset, asynchronous, active-high.
- tick_clk  input  1  divided clock from the clock divider. Asynchronous level; its rising edges are tempo ticks.
- start  input  1  pulse or level that starts playback from IDLE.
- stop  input  1  aborts playback.
- loop  input  1  when high, the sequence wraps from note 7 back to note 0.
- audio_out  output  1  square-wave tone, low when silent.
- busy  output  1  high in PLAY or GAP.
- note_idx  output  3  index of the current note, 0..7.
- done  output  1  one-cycle pulse when a non-looping sequence finishes.

## Operation
- **Tick detection:**
  - tick_clk passes through a 2-flop synchroniser (s1, s2) and a third register s3.
  - tick = s2 & ~s3.
  - Each tick is a single clk_in-cycle pulse.
- **Note table** (half-period in clk_in cycles = CLK_HZ / (2·f), truncated):

  | note_idx | Note | f (Hz) |
  |---|---|---|
  | 0 | C4 | 262 |
  | 1 | D4 | 294 |
  | 2 | E4 | 330 |
  | 3 | F4 | 349 |
  | 4 | G4 | 392 |
  | 5 | A4 | 440 |
  | 6 | B4 | 494 |
  | 7 | C5 | 523 |

  - At CLK_HZ=50000000, C4 = 95419 and A4 = 56818.
  - half_cnt is 32 bits wide.
- **State machine:** IDLE, PLAY, GAP.
  - IDLE to PLAY: start=1 and stop=0. Sets note_idx=0, half_cnt=0, tone=0, tick_cnt=0.
  - PLAY:
    - half_cnt increments every cycle.
    - When half_cnt == half_period(note_idx)-1, tone toggles and half_cnt returns to 0.
    - tick_cnt increments on each tick.
    - A tick with tick_cnt == NOTE_TICKS-1 ends the note.
  - End of note:
    - If GAP_TICKS > 0: go to GAP with tick_cnt=0 and tone=0.
    - If GAP_TICKS = 0: apply the advance rule immediately.
  - GAP: audio_out=0. A tick with tick_cnt == GAP_TICKS-1 applies the advance rule.
  - Advance rule:
    - If note_idx < 7: note_idx+1, enter PLAY with counters and tone cleared.
    - If note_idx == 7 and loop=1: note_idx=0, enter PLAY.
    - If note_idx == 7 and loop=0: go to IDLE and pulse done for 1 cycle.
  - stop=1 in PLAY or GAP: go to IDLE on the next edge, with tone=0, note_idx=0 and no done pulse.
- **Input precedence:**
  - stop beats start in IDLE; the block stays in IDLE.
  - start is ignored while busy.
- **Note length:** the first tick of a note may be partial, so a note lasts between NOTE_TICKS-1 and NOTE_TICKS tick periods.
- loop is sampled only at the note-7 advance decision.
- **Outputs:**
  - audio_out = tone register, forced 0 outside PLAY.
  - busy = (state != IDLE).
  - All outputs are registered.

## Timing
- **Reset values:** state=IDLE, audio_out=0, busy=0, note_idx=0, done=0, all counters 0, s1/s2/s3=0. Reset is asynchronous and takes effect immediately mid-playback.
- **start latency:** start sampled high at edge N gives busy=1 after edge N. The first tone toggle occurs half_period(0) cycles later.
- **Tick latency:** a tick_clk rising edge produces the tick pulse 2–3 clk_in cycles later. The state change is registered on that cycle's edge.
- done is high for exactly 1 cycle, in the same cycle busy falls.
- **Tone period:** exactly 2·half_period clk_in cycles, with a 50% duty cycle.

## Test plan
1. Assert rst mid-stream with random inputs → audio_out, busy, done = 0 and note_idx = 0 immediately. The block stays idle after release.
2. CLK_HZ=5240, NOTE_TICKS=2, GAP_TICKS=1, tick_clk period 400 cycles, pulse start → busy=1 and audio_out toggles every 10 cycles (C4). After 2 ticks plus 1 gap tick, note_idx=1 and audio_out toggles every 8 cycles (D4, 5240/588).
3. Same setup, loop=0, run to the end → note_idx steps 0..7; A4 toggles every 5 cycles. After note 7's gap, done pulses for 1 cycle, busy=0, note_idx=0.
4. loop=1 → note_idx wraps from 7 to 0, done never asserts, busy stays 1 for 3 full sequences.
5. Assert stop during note 3 → next cycle busy=0, audio_out=0, note_idx=0, no done. Pulse start while busy → ignored, note_idx is not reset. start and stop together in IDLE → stays IDLE.
6. GAP_TICKS=0 → there is no silent interval: note_idx advances on the ending tick and the new tone starts immediately.
